csa_sub_pipe_35bit: RTL and testbench



---
 rtl/csa_sub_pipe_35bit.sv | 157 +++++++++++++++
 tb/tb_csa_sub_pipe_35bit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/csa_sub_pipe_35bit.sv
// csa_sub_pipe_35bit
//   Two-stage pipelined 35-bit carry-select subtractor with valid/ready on
//   both sides. diff = term1 + ~term2 + 1, borrow = ~carry_out(msb).
//   Stage 1 resolves diff[SPLIT-1:0] (ripple slice + carry-select slices)
//   and registers the carry plus the upper operand halves. Stage 2 resolves
//   the upper bits with carry-select slices chained on that carry.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   i_valid / o_ready   input handshake (o_ready depends combinationally
//                       on i_ready only)
//   i_sub_term1/2       minuend / subtrahend, sampled on acceptance
//   o_valid / i_ready   output handshake
//   diff, borrow        registered result; held while o_valid && !i_ready
//
// Config macro
//   CSA_SUB_SAT_EN      when defined, diff saturates to 0 on borrow.

module csa_sub_slice #(
  parameter int W      = 4,
  parameter int RIPPLE = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  generate
    if (RIPPLE != 0) begin : g_ripple
      assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end else begin : g_csel
      // Both carry-in outcomes are precomputed; the late carry only steers the mux.
      logic [W:0] sum0, sum1;
      assign sum0 = {1'b0, a} + {1'b0, b};
      assign sum1 = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, 1'b1};
      assign {cout, s} = cin ? sum1 : sum0;
    end
  endgenerate
endmodule

module csa_sub_pipe_35bit #(
  parameter int WIDTH      = 35,
  parameter int BIT_REMAIN = 3,
  parameter int SPLIT      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_sub_term1,
  input  logic [WIDTH-1:0] i_sub_term2,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);
  localparam int N1 = SPLIT / 4;
  localparam int HI = WIDTH - SPLIT;
  localparam int N2 = HI / 4;

  logic             s1_v, s2_v;
  logic [SPLIT-1:0] s1_lo;
  logic             s1_c;
  logic [HI-1:0]    s1_a, s1_nb;

  logic s2_adv, s1_adv, accept, xfer;
  assign s2_adv  = !s2_v || i_ready;
  assign s1_adv  = !s1_v || s2_adv;
  assign o_ready = s1_adv;
  assign accept  = i_valid && s1_adv;
  assign xfer    = s1_v && s2_adv;
  assign o_valid = s2_v;

  // ---------------- stage 1: low bits ----------------
  logic [WIDTH-1:0] nb;
  logic [N1:0]      c1;
  logic [SPLIT-1:0] lo_sum;
  assign nb    = ~i_sub_term2;
  assign c1[0] = 1'b1;  // +1 of the two's-complement negate

  genvar g;
  generate
    for (g = 0; g < N1; g++) begin : g_s1
      csa_sub_slice #(.W(4), .RIPPLE(g == 0 ? 1 : 0)) u_slice (
        .a   (i_sub_term1[4*g +: 4]),
        .b   (nb[4*g +: 4]),
        .cin (c1[g]),
        .s   (lo_sum[4*g +: 4]),
        .cout(c1[g+1])
      );
    end
  endgenerate

  // ---------------- stage 2: high bits ----------------
  logic [N2+1:0] c2;
  logic [HI-1:0] hi_sum;
  assign c2[0] = s1_c;

  generate
    for (g = 0; g < N2; g++) begin : g_s2
      csa_sub_slice #(.W(4), .RIPPLE(0)) u_slice (
        .a   (s1_a[4*g +: 4]),
        .b   (s1_nb[4*g +: 4]),
        .cin (c2[g]),
        .s   (hi_sum[4*g +: 4]),
        .cout(c2[g+1])
      );
    end
  endgenerate

  csa_sub_slice #(.W(BIT_REMAIN), .RIPPLE(0)) u_top (
    .a   (s1_a[HI-1 -: BIT_REMAIN]),
    .b   (s1_nb[HI-1 -: BIT_REMAIN]),
    .cin (c2[N2]),
    .s   (hi_sum[HI-1 -: BIT_REMAIN]),
    .cout(c2[N2+1])
  );

  logic             borrow_nxt;
  logic [WIDTH-1:0] diff_nxt;
  assign borrow_nxt = ~c2[N2+1];
`ifdef CSA_SUB_SAT_EN
  assign diff_nxt = borrow_nxt ? '0 : {hi_sum, s1_lo};
`else
  assign diff_nxt = {hi_sum, s1_lo};
`endif

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      s1_lo  <= '0;
      s1_c   <= 1'b0;
      s1_a   <= '0;
      s1_nb  <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      if (s1_adv) s1_v <= i_valid;
      if (accept) begin
        s1_lo <= lo_sum;
        s1_c  <= c1[N1];
        s1_a  <= i_sub_term1[WIDTH-1:SPLIT];
        s1_nb <= nb[WIDTH-1:SPLIT];
      end
      if (s2_adv) s2_v <= s1_v;
      // Result regs only move on a real transfer so a drained output holds
      // its last value instead of picking up stage-1 leftovers.
      if (xfer) begin
        diff   <= diff_nxt;
        borrow <= borrow_nxt;
      end
    end
  end
endmodule

// File: tb/tb_csa_sub_pipe_35bit.sv
module tb_csa_sub_pipe_35bit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, o_ready, o_valid, i_ready, borrow;
  logic [34:0] i_sub_term1, i_sub_term2, diff;

  int checks = 0;
  int errors = 0;
  int nout   = 0;
  logic [35:0] q[$];
  logic        stall_prev = 1'b0;
  logic [35:0] stall_val  = '0;

`ifdef CSA_SUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  csa_sub_pipe_35bit dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_sub_term1(i_sub_term1), .i_sub_term2(i_sub_term2),
    .o_valid(o_valid), .i_ready(i_ready), .diff(diff), .borrow(borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] model(input logic [34:0] a, input logic [34:0] b);
    logic [34:0] d;
    logic        br;
    d  = a - b;
    br = (a < b);
    if (SAT && br) d = '0;
    return {br, d};
  endfunction

  function automatic logic [34:0] rnd35();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 35'h7_FFFF_FFFF;
      2:       return 35'h0_0001_0000;
      default: return r[34:0];
    endcase
  endfunction

  task automatic set_in(input logic iv, input logic ir, input logic [34:0] a, input logic [34:0] b);
    i_valid = iv; i_ready = ir; i_sub_term1 = a; i_sub_term2 = b;
  endtask

  // One cycle, called at a negedge: drive, settle, score, advance.
  task automatic sb_cycle(input logic iv, input logic ir, input logic [34:0] a, input logic [34:0] b);
    logic [35:0] e;
    set_in(iv, ir, a, b);
    #1;
    if (stall_prev) begin
      chk("stall_valid", o_valid, 1);
      chk("stall_data", {borrow, diff}, stall_val);
    end
    if (o_valid && i_ready) begin
      chk("sb_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_result", {borrow, diff}, e);
      end
      nout++;
    end
    if (i_valid && o_ready) q.push_back(model(a, b));
    stall_prev = o_valid && !i_ready;
    stall_val  = {borrow, diff};
    @(negedge clk);
  endtask

  initial begin
    int n0;
    rst_n = 1'b0;
    set_in(0, 0, '0, '0);
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_o_valid", o_valid, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_o_ready", o_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // basic 16 - 3, two-edge latency
    set_in(1, 1, 35'h0_0000_0010, 35'h0_0000_0003);
    @(negedge clk);
    chk("lat_early", o_valid, 0);
    set_in(0, 1, '0, '0);
    @(negedge clk);
    chk("basic_valid", o_valid, 1);
    chk("basic_diff", diff, 35'h0_0000_000D);
    chk("basic_borrow", borrow, 0);
    @(negedge clk);
    chk("basic_drop", o_valid, 0);

    // borrow across the stage split, back to back
    set_in(1, 1, 35'h0_0001_0000, 35'h0_0000_0001);
    @(negedge clk);
    set_in(1, 1, 35'h0, 35'h0_0000_0001);
    @(negedge clk);
    set_in(0, 1, '0, '0);
    chk("split_valid", o_valid, 1);
    chk("split_diff", diff, 35'h0_0000_FFFF);
    chk("split_borrow", borrow, 0);
    @(negedge clk);
    chk("under_valid", o_valid, 1);
    chk("under_diff", diff, SAT ? 35'h0 : 35'h7_FFFF_FFFF);
    chk("under_borrow", borrow, 1);
    @(negedge clk);

    // backpressure: 5 cycles with i_ready=0, 3 items
    set_in(1, 0, 35'd100, 35'd1);
    #1 chk("bp_ready0", o_ready, 1);
    @(negedge clk);
    set_in(1, 0, 35'd5, 35'd7);
    #1 chk("bp_ready1", o_ready, 1);
    @(negedge clk);
    set_in(1, 0, 35'h1_2345_6789, 35'h0_0000_0042);  // must be ignored
    #1 chk("bp_full", o_ready, 0);
    chk("bp_hold_v", o_valid, 1);
    chk("bp_hold_d", diff, 35'd99);
    @(negedge clk);
    set_in(1, 0, 35'h7_7777_7777, 35'h0_0000_0001);  // must be ignored
    #1 chk("bp_full2", o_ready, 0);
    chk("bp_hold_d2", diff, 35'd99);
    @(negedge clk);
    set_in(1, 0, 35'h4_0000_0000, 35'h0_0000_0001);
    #1 chk("bp_hold_d3", diff, 35'd99);
    @(negedge clk);
    set_in(1, 1, 35'h4_0000_0000, 35'h0_0000_0001);
    #1 chk("bp_release", o_ready, 1);
    chk("bp_item0", {borrow, diff}, {1'b0, 35'd99});
    @(negedge clk);
    set_in(0, 1, '0, '0);
    chk("bp_item1", {borrow, diff}, {1'b1, SAT ? 35'h0 : 35'h7_FFFF_FFFE});
    @(negedge clk);
    chk("bp_item2", {borrow, diff}, {1'b0, 35'h3_FFFF_FFFF});
    chk("bp_item2_v", o_valid, 1);
    @(negedge clk);
    chk("bp_no_dup", o_valid, 0);

    // back-to-back stream of 100
    n0 = nout;
    for (int i = 0; i < 100; i++) sb_cycle(1, 1, rnd35(), rnd35());
    chk("stream_rate", nout - n0, 98);
    for (int i = 0; i < 10 && q.size() != 0; i++) sb_cycle(0, 1, '0, '0);
    chk("stream_count", nout - n0, 100);

    // random valid/ready toggling
    for (int i = 0; i < 4000; i++)
      sb_cycle(($urandom % 4) != 0, ($urandom % 3) != 0, rnd35(), rnd35());
    for (int i = 0; i < 10 && q.size() != 0; i++) sb_cycle(0, 1, '0, '0);
    chk("rand_drained", q.size(), 0);

    // reset with both stages full
    sb_cycle(1, 0, 35'd50, 35'd8);
    sb_cycle(1, 0, 35'd60, 35'd9);
    rst_n = 1'b0;
    set_in(1, 0, 35'd70, 35'd1);
    @(negedge clk);
    chk("mrst_valid", o_valid, 0);
    chk("mrst_diff", diff, 0);
    chk("mrst_borrow", borrow, 0);
    chk("mrst_ready", o_ready, 1);
    rst_n = 1'b1;
    q.delete();
    stall_prev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, '0, '0);
      #1 chk("mrst_no_stale", o_valid, 0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
